// File: rtl/bnn_xnor_acc.sv
// bnn_xnor_acc: binary XNOR-popcount accumulator over two memory vectors, thresholded result written back.
module bnn_xnor_acc #(
   parameter int DATA_W = 32,
   parameter int MEM_AW = 14,
   parameter int ACC_W  = 16,
   parameter int LEN_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_wen,
   input  logic [31:0]         cfg_addr,
   input  logic [DATA_W-1:0]   cfg_wdata,
   output logic [DATA_W-1:0]   cfg_rdata,
   output logic                mem_ren,
   output logic                mem_wen,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy,
   output logic                done
);
   typedef enum logic [2:0] {IDLE, RD_IN, RD_W, MAC, WR, FIN} state_t;
   localparam logic [15:0] A_IN = 16'h0008, A_W = 16'h000C, A_CTRL = 16'h0010, A_OUT = 16'h0014,
                           A_TH = 16'h0018, A_STAT = 16'h001C, A_ACC = 16'h0020;
   state_t state_q, state_d;
   logic [MEM_AW-1:0] in_base_q, w_base_q, out_addr_q, in_s_q, w_s_q, out_s_q, addr_d;
   logic [DATA_W-1:0] thresh_q, thresh_s_q, in_word_q, wdata_d;
   logic [LEN_W-1:0]  len_q, len_s_q, i_q, i_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W:0]    sum;
   logic              accum_q, go_q, busy_q, done_q, done_st_q, err_st_q, mem_ren_q, mem_wen_q;
   logic [DATA_W/8-1:0] mem_be_q;
   logic [MEM_AW-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [15:0]       sel;
   logic              start, launch, last, unused_addr;
   assign sel         = cfg_addr[31:16];
   assign unused_addr = ^cfg_addr[15:0];
   assign start       = cfg_wen && sel == A_CTRL && cfg_wdata[0];
   assign launch      = start && !busy_q;
   assign last        = i_q == len_s_q - 1'b1;
   assign sum         = {1'b0, acc_q} + (ACC_W+1)'($countones(~(in_word_q ^ mem_rdata)));
   assign cfg_rdata = sel == A_IN   ? DATA_W'(in_base_q) :
                      sel == A_W    ? DATA_W'(w_base_q) :
                      sel == A_CTRL ? DATA_W'({len_q, 6'b0, accum_q, 1'b0}) :
                      sel == A_OUT  ? DATA_W'(out_addr_q) :
                      sel == A_TH   ? thresh_q :
                      sel == A_STAT ? DATA_W'({err_st_q, done_st_q, busy_q}) :
                      sel == A_ACC  ? DATA_W'(acc_q) : '0;
   always_comb begin
      state_d = state_q == IDLE  ? (go_q ? (len_s_q == '0 ? WR : RD_IN) : IDLE) :
                state_q == RD_IN ? RD_W :
                state_q == RD_W  ? MAC :
                state_q == MAC   ? (last ? WR : RD_IN) :
                state_q == WR    ? FIN : IDLE;
      i_d     = launch ? '0 : state_q == MAC ? i_q + 1'b1 : i_q;
      // saturate instead of wrapping once the sum carries out of ACC_W bits
      acc_d   = launch ? (cfg_wdata[1] ? acc_q : '0) :
                state_q == MAC ? (sum[ACC_W] ? '1 : sum[ACC_W-1:0]) : acc_q;
      addr_d  = state_d == RD_IN ? in_s_q + MEM_AW'(i_d) :
                state_d == RD_W  ? w_s_q + MEM_AW'(i_d) :
                state_d == WR    ? out_s_q : '0;
      wdata_d = '0;
      wdata_d[ACC_W-1:0] = acc_d;
      wdata_d[DATA_W-1]  = DATA_W'(acc_d) >= thresh_s_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         {in_base_q, w_base_q, out_addr_q, in_s_q, w_s_q, out_s_q} <= '0;
         {thresh_q, thresh_s_q, in_word_q, len_q, len_s_q, i_q, acc_q} <= '0;
         {accum_q, go_q, busy_q, done_q, done_st_q, err_st_q} <= '0;
         {mem_ren_q, mem_wen_q, mem_be_q, mem_addr_q, mem_wdata_q} <= '0;
      end else begin
         if (cfg_wen && sel == A_IN) in_base_q <= cfg_wdata[MEM_AW-1:0];
         if (cfg_wen && sel == A_W) w_base_q <= cfg_wdata[MEM_AW-1:0];
         if (cfg_wen && sel == A_OUT) out_addr_q <= cfg_wdata[MEM_AW-1:0];
         if (cfg_wen && sel == A_TH) thresh_q <= cfg_wdata;
         if (cfg_wen && sel == A_CTRL) {len_q, accum_q} <= {cfg_wdata[8+:LEN_W], cfg_wdata[1]};
         if (launch) {in_s_q, w_s_q, out_s_q, thresh_s_q, len_s_q} <=
            {in_base_q, w_base_q, out_addr_q, thresh_q, cfg_wdata[8+:LEN_W]};
         err_st_q  <= (start && busy_q) ? 1'b1 : (cfg_wen && sel == A_STAT && cfg_wdata[2]) ? 1'b0 : err_st_q;
         done_st_q <= state_q == FIN ? 1'b1 : start ? 1'b0 : done_st_q;
         state_q   <= state_d;
         i_q       <= i_d;
         acc_q     <= acc_d;
         go_q      <= launch;
         busy_q    <= launch || state_d != IDLE;
         done_q    <= state_q == FIN;
         in_word_q <= state_q == RD_W ? mem_rdata : in_word_q;
         mem_ren_q <= state_d == RD_IN || state_d == RD_W;
         mem_wen_q <= state_d == WR;
         mem_be_q  <= {(DATA_W/8){state_d == WR}};
         mem_addr_q  <= addr_d;
         mem_wdata_q <= state_d == WR ? wdata_d : '0;
      end
   end
   assign mem_ren   = mem_ren_q;
   assign mem_wen   = mem_wen_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule

// File: tb/tb_bnn_xnor_acc.sv
// tb_bnn_xnor_acc: directed bench for bnn_xnor_acc with a behavioural word memory.
module tb_bnn_xnor_acc;
   localparam logic [15:0] A_IN = 16'h0008, A_W = 16'h000C, A_CTRL = 16'h0010, A_OUT = 16'h0014,
                           A_TH = 16'h0018, A_STAT = 16'h001C, A_ACC = 16'h0020;
   logic        clk, rst, cfg_wen, mem_ren, mem_wen, busy, done, log_en;
   logic [31:0] cfg_addr, cfg_wdata, cfg_rdata, mem_wdata, mem_rdata, rd, st;
   logic [3:0]  mem_be;
   logic [13:0] mem_addr;
   logic [31:0] mem [0:16383];
   logic [13:0] ra [0:7];
   int          n_chk, n_err, wr_cnt, both_cnt, rn, lat, wb;

   bnn_xnor_acc dut (
      .clk(clk), .rst(rst), .cfg_wen(cfg_wen), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_rdata(cfg_rdata), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_ren) mem_rdata <= mem[mem_addr];
      if (mem_ren && log_en && rn < 8) begin
         ra[rn] = mem_addr;
         rn++;
      end
      if (mem_wen) begin
         for (int b = 0; b < 4; b++) if (mem_be[b]) mem[mem_addr][8*b+:8] = mem_wdata[8*b+:8];
         wr_cnt++;
      end
      if (mem_ren && mem_wen) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cfg_wr(input logic [15:0] r, input logic [31:0] d);
      @(negedge clk);
      cfg_addr = {r, 16'h0}; cfg_wdata = d; cfg_wen = 1;
      @(negedge clk);
      cfg_wen = 0;
   endtask

   task automatic cfg_rd(input logic [15:0] r, output logic [31:0] d);
      @(negedge clk);
      cfg_addr = {r, 16'h0};
      #1 d = cfg_rdata;
   endtask

   task automatic setup(input logic [31:0] ib, input logic [31:0] wbase, input logic [31:0] ob, input logic [31:0] th);
      cfg_wr(A_IN, ib); cfg_wr(A_W, wbase); cfg_wr(A_OUT, ob); cfg_wr(A_TH, th);
   endtask

   task automatic start_wr(input int len, input bit acm);
      @(negedge clk);
      cfg_addr = {A_CTRL, 16'h0}; cfg_wdata = (len << 8) | (32'(acm) << 1) | 32'h1; cfg_wen = 1;
      @(posedge clk);
      #1 cfg_wen = 0; cfg_addr = {A_STAT, 16'h0};
   endtask

   // lat = edges after the START write edge until done is seen, -1 on timeout
   task automatic run(input int len, input bit acm, input bit inj, output int l, output logic [31:0] s1);
      start_wr(len, acm);
      #1 s1 = cfg_rdata;
      l = -1;
      for (int k = 1; k <= 1000 && l < 0; k++) begin
         @(posedge clk);
         #1;
         if (done) l = k;
         if (inj && k == 4) begin cfg_addr = {A_CTRL, 16'h0}; cfg_wdata = 32'h101; cfg_wen = 1; end
         if (inj && k == 5) begin cfg_wen = 0; cfg_addr = {A_STAT, 16'h0}; end
      end
   endtask

   initial begin
      rst = 1; cfg_wen = 0; cfg_addr = 0; cfg_wdata = 0; log_en = 0;
      n_chk = 0; n_err = 0;
      for (int i = 0; i < 16384; i++) mem[i] = 0;
      repeat (3) @(posedge clk);
      #1 check("rst_ctl", {28'h0, busy, done, mem_ren, mem_wen}, 32'h0);
      check("rst_addr_data", {18'h0, mem_addr} | mem_wdata | {28'h0, mem_be}, 32'h0);
      @(negedge clk) rst = 0;
      repeat (3) @(posedge clk);
      #1 check("idle_after_rst", {31'h0, busy}, 32'h0);
      cfg_rd(A_STAT, rd); check("status_rst", rd, 32'h0);
      cfg_rd(A_ACC, rd); check("acc_rst", rd, 32'h0);
      cfg_wr(A_IN, 32'h12345); cfg_rd(A_IN, rd); check("in_base_trunc", rd, 32'h2345);
      cfg_wr(16'h0004, 32'hDEAD); cfg_rd(16'h0004, rd); check("unmapped", rd, 32'h0);

      mem[16'h10] = 32'hFFFF_FFFF; mem[16'h40] = 32'h7;
      setup(32'h10, 32'h40, 32'h80, 3);
      run(1, 0, 0, lat, st);
      check("t1_lat", lat, 6);
      check("t1_out", mem[16'h80], 32'h8000_0003);
      cfg_rd(A_ACC, rd); check("t1_acc", rd, 3);
      cfg_rd(A_STAT, rd); check("t1_status", rd, 32'h2);

      for (int i = 0; i < 4; i++) begin mem[16'h100 + i] = '1; mem[16'h200 + i] = '1; end
      setup(32'h100, 32'h200, 32'h90, 200);
      run(4, 0, 0, lat, st);
      check("t2_lat", lat, 15);
      check("t2_out", mem[16'h90], 32'h0000_0080);
      run(4, 1, 0, lat, st);
      check("t2_accum_out", mem[16'h90], 32'h8000_0100);

      rn = 0; log_en = 1;
      setup(32'h3FFF, 32'h20, 32'hA0, 200);
      run(2, 0, 0, lat, st);
      log_en = 0;
      check("t3_nreads", rn, 4);
      check("t3_ra0", {18'h0, ra[0]}, 32'h3FFF);
      check("t3_ra1", {18'h0, ra[1]}, 32'h20);
      check("t3_ra2", {18'h0, ra[2]}, 32'h0);
      check("t3_ra3", {18'h0, ra[3]}, 32'h21);
      check("t3_out", mem[16'hA0], 32'h40);
      cfg_rd(A_STAT, rd); check("t3_status", rd, 32'h2);

      setup(32'h100, 32'h200, 32'hB0, 200);
      run(4, 0, 1, lat, st);
      check("t4_lat", lat, 15);
      check("t4_out", mem[16'hB0], 32'h80);
      cfg_rd(A_STAT, rd); check("t4_err", rd, 32'h6);
      cfg_wr(A_STAT, 32'h4); cfg_rd(A_STAT, rd); check("t4_err_clr", rd, 32'h2);
      cfg_wr(A_OUT, 32'hC0);
      wb = wr_cnt;
      run(0, 1, 0, lat, st);
      check("t4_len0_lat", lat, 3);
      check("t4_len0_st1", st, 32'h1);
      check("t4_len0_out", mem[16'hC0], 32'h80);
      check("t4_len0_nwr", wr_cnt - wb, 1);

      setup(32'h100, 32'h200, 32'hE0, 200);
      wb = wr_cnt;
      start_wr(8, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1;
      #1 check("t5_rst_ctl", {28'h0, busy, done, mem_ren, mem_wen}, 32'h0);
      cfg_rd(A_ACC, rd); check("t5_acc", rd, 32'h0);
      @(negedge clk) rst = 0;
      repeat (40) @(posedge clk);
      #1 check("t5_no_write", wr_cnt - wb, 0);
      check("t5_mem", mem[16'hE0], 32'h0);
      check("t5_idle", {31'h0, busy}, 32'h0);
      setup(32'h100, 32'h200, 32'hD0, 200);
      run(4, 0, 0, lat, st);
      check("t5_rerun", mem[16'hD0], 32'h80);

      setup(32'h1000, 32'h1000, 32'hF0, 0);
      for (int r = 0; r < 9; r++) begin
         run(255, r != 0, 0, lat, st);
         if (r == 7) begin cfg_rd(A_ACC, rd); check("t6_acc8", rd, 32'hFF00); end
      end
      check("t6_lat", lat, 768);
      cfg_rd(A_ACC, rd); check("t6_sat", rd, 32'hFFFF);
      check("t6_out", mem[16'hF0], 32'h8000_FFFF);
      check("ren_wen_excl", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/bnn_xnor_acc.md
BNN_XNOR_ACC -- requirements
Module: bnn_xnor_acc

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 32, memory/config data width (multiple of 8).
- MEM_AW, 14, memory word-address width.
- ACC_W, 16, accumulator width (ACC_W <= DATA_W-1).
- LEN_W, 8, run-length field width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_wen  in  1  config register write strobe.
- cfg_addr  in  32  config address; cfg_addr[31:16] selects the register.
- cfg_wdata  in  DATA_W  config write data.
- cfg_rdata  out  DATA_W  readback of the register selected by cfg_addr (combinational).
- mem_ren  out  1  memory read request.
- mem_wen  out  1  memory write request.
- mem_be  out  DATA_W/8  byte enables for writes.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_ren.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
REQ-003 Register map (cfg_addr[31:16]): 0x0008 IN_BASE, 0x000C W_BASE, 0x0010 CTRL (bit0 START, bit1 ACCUM, [8+LEN_W-1:8] LEN), 0x0014 OUT_ADDR, 0x0018 THRESH, 0x001C STATUS (RO: bit0 busy, bit1 done_sticky, bit2 err_sticky), 0x0020 ACC (RO); unmapped reads return 0, unmapped writes ignored.

Function
REQ-004 Config registers write on the clk edge with cfg_wen high, busy or not; address fields keep their low MEM_AW bits.
REQ-005 START=1 while idle snapshots IN_BASE, W_BASE, OUT_ADDR, THRESH, LEN, ACCUM, enters RD_IN next cycle; START is self-clearing, never stored.
REQ-006 START=1 while busy is ignored and sets err_sticky; writing 1 to STATUS bit2 clears err_sticky; START=1 clears done_sticky.
REQ-007 FSM states: IDLE, RD_IN, RD_W, MAC, WR, FIN.
REQ-008 RD_IN: mem_ren=1, mem_addr=IN_BASE+i, next RD_W.
REQ-009 RD_W: mem_ren=1, mem_addr=W_BASE+i, latch mem_rdata as in_word, next MAC.
REQ-010 MAC: acc <= acc + popcount(~(in_word ^ mem_rdata)); i++; next WR if i==LEN-1, else RD_IN.
REQ-011 Address arithmetic modulo 2^MEM_AW; base+i wraps without error.
REQ-012 acc saturates at 2^ACC_W-1; never wraps.
REQ-013 At start acc clears to 0 if ACCUM=0; retains prior value if ACCUM=1.
REQ-014 LEN=0: FSM goes directly to WR (no reads).
REQ-015 WR: mem_wen=1, mem_be all ones, mem_addr=OUT_ADDR, mem_wdata[ACC_W-1:0]=acc, mem_wdata[DATA_W-1]=(acc>=THRESH), other bits 0; next FIN.
REQ-016 FIN: done=1 for one cycle, done_sticky set, next IDLE.
REQ-017 busy=1 in every state except IDLE; mem_ren and mem_wen never high together.
REQ-018 Latency: start write edge to done pulse = 3*LEN+3 cycles.
REQ-019 All outputs are driven from registered state; no combinational path cfg inputs -> mem outputs.

Reset
REQ-020 rst asserted, at any time including mid-run, immediately forces IDLE; clears all registers, acc, i and sticky bits to 0; mem_ren, mem_wen, mem_be, mem_addr, mem_wdata, busy, done all 0; no partial write completes.
REQ-021 After rst deasserts, the block stays IDLE until a START write.

Verification
REQ-022 IN_BASE=0x10, W_BASE=0x40, OUT_ADDR=0x80, THRESH=3, LEN=1; mem[0x10]=0xFFFF_FFFF, mem[0x40]=0x0000_0007 -> mem[0x80]=0x8000_0003, done at cycle 6 after start.
REQ-023 LEN=4, in=w=0xFFFF_FFFF each word, THRESH=200 -> acc=128, mem[OUT_ADDR]=0x0000_0080; rerun with ACCUM=1 -> 0x8000_0100.
REQ-024 IN_BASE=0x3FFF, LEN=2 -> read addresses 0x3FFF then 0x0000; no error.
REQ-025 START written during run -> err_sticky=1, run completes unchanged; LEN=0 -> single write of acc, done 3 cycles after start.
REQ-026 rst pulsed during MAC of LEN=8 run -> busy=0, mem_wen never asserted, ACC reads 0, next run correct.
REQ-027 ACCUM=1 runs pushing acc past 65535 (ACC_W=16) -> acc holds 0xFFFF.
